// File: rtl/ann_sequencer.sv
// Layer/neuron sequencer for the ANN classifier: walks hidden then output layer,
// handshakes coefficients and MAC, tracks the output argmax, drives the 7-seg digit.
module ann_sequencer #(
  parameter int N_HIDDEN = 16,
  parameter int N_OUT    = 10,
  parameter int ACC_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             image_weights_loaded,
  input  logic             start,
  input  logic             coef_ack,
  input  logic             mac_done,
  input  logic [ACC_W-1:0] mac_result,
  output logic             request_coef,
  output logic             coef_select,
  output logic [3:0]       node_idx,
  output logic             mac_start,
  output logic             busy,
  output logic             done_processing,
  output logic             aborted,
  output logic [7:0]       seven_seg
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LOAD,
    S_REQ,
    S_FIRE,
    S_WAIT_MAC,
    S_DONE
  } state_t;

  localparam logic [3:0]       LAST_H    = 4'(N_HIDDEN - 1);
  localparam logic [3:0]       LAST_O    = 4'(N_OUT - 1);
  localparam logic [ACC_W-1:0] BEST_INIT = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                   r_state;
  logic signed [ACC_W-1:0]  r_best_val;
  logic [3:0]               r_best_idx;

  logic signed [ACC_W-1:0]  w_res;
  logic                     w_better;
  logic [3:0]               w_final_idx;
  logic                     w_abort;

  assign w_res       = $signed(mac_result);
  assign w_better    = coef_select && (w_res > r_best_val);
  // The final output result is folded in here so the digit latched on entry to
  // DONE already accounts for it.
  assign w_final_idx = w_better ? node_idx : r_best_idx;
  assign w_abort     = !image_weights_loaded &&
                       (r_state == S_REQ || r_state == S_FIRE || r_state == S_WAIT_MAC);

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 8'h3F;
      4'd1:    seg_of = 8'h06;
      4'd2:    seg_of = 8'h5B;
      4'd3:    seg_of = 8'h4F;
      4'd4:    seg_of = 8'h66;
      4'd5:    seg_of = 8'h6D;
      4'd6:    seg_of = 8'h7D;
      4'd7:    seg_of = 8'h07;
      4'd8:    seg_of = 8'h7F;
      4'd9:    seg_of = 8'h6F;
      default: seg_of = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      request_coef    <= 1'b0;
      coef_select     <= 1'b0;
      node_idx        <= '0;
      mac_start       <= 1'b0;
      busy            <= 1'b0;
      done_processing <= 1'b0;
      aborted         <= 1'b0;
      seven_seg       <= '0;
      r_best_val      <= '0;
      r_best_idx      <= '0;
    end else begin
      mac_start       <= 1'b0;
      done_processing <= 1'b0;
      aborted         <= 1'b0;
      if (w_abort) begin
        r_state      <= S_IDLE;
        request_coef <= 1'b0;
        busy         <= 1'b0;
        aborted      <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              busy        <= 1'b1;
              node_idx    <= '0;
              coef_select <= 1'b0;
              r_best_val  <= BEST_INIT;
              r_best_idx  <= '0;
              if (image_weights_loaded) begin
                r_state      <= S_REQ;
                request_coef <= 1'b1;
              end else begin
                r_state <= S_WAIT_LOAD;
              end
            end
          end
          S_WAIT_LOAD: begin
            if (image_weights_loaded) begin
              r_state      <= S_REQ;
              request_coef <= 1'b1;
            end
          end
          S_REQ: begin
            if (coef_ack) begin
              request_coef <= 1'b0;
              mac_start    <= 1'b1;
              r_state      <= S_FIRE;
            end
          end
          S_FIRE: r_state <= S_WAIT_MAC;
          S_WAIT_MAC: begin
            if (mac_done) begin
              if (w_better) begin
                r_best_val <= w_res;
                r_best_idx <= node_idx;
              end
              if (coef_select && node_idx == LAST_O) begin
                r_state         <= S_DONE;
                done_processing <= 1'b1;
                seven_seg       <= seg_of(w_final_idx);
              end else begin
                r_state      <= S_REQ;
                request_coef <= 1'b1;
                if (!coef_select && node_idx == LAST_H) begin
                  coef_select <= 1'b1;
                  node_idx    <= '0;
                end else begin
                  node_idx <= node_idx + 4'd1;
                end
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ann_sequencer.sv
// Directed bench for ann_sequencer (4 hidden, 3 output neurons) with an argmax
// model and a per-cycle output monitor.
module tb_ann_sequencer;

  localparam int NH = 4;
  localparam int NO = 3;
  localparam logic [7:0] SEG_TAB [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                          8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        image_weights_loaded = 1'b0;
  logic        start = 1'b0;
  logic        coef_ack = 1'b0;
  logic        mac_done = 1'b0;
  logic [15:0] mac_result = '0;
  logic        request_coef, coef_select, mac_start, busy, done_processing, aborted;
  logic [3:0]  node_idx;
  logic [7:0]  seven_seg;

  int          n_checks = 0;
  int          n_fail = 0;
  int          tot_ms = 0;
  int          tot_done = 0;
  logic [7:0]  m_pending_seg = '0;

  ann_sequencer #(.N_HIDDEN(NH), .N_OUT(NO), .ACC_W(16)) dut (
    .clk(clk), .rst(rst), .image_weights_loaded(image_weights_loaded),
    .start(start), .coef_ack(coef_ack), .mac_done(mac_done), .mac_result(mac_result),
    .request_coef(request_coef), .coef_select(coef_select), .node_idx(node_idx),
    .mac_start(mac_start), .busy(busy), .done_processing(done_processing),
    .aborted(aborted), .seven_seg(seven_seg)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_seg(input int a, input int b, input int c);
    int v[3];
    int best;
    int bi;
    v[0] = a; v[1] = b; v[2] = c;
    best = -32768;
    bi = 0;
    for (int i = 0; i < NO; i++)
      if (v[i] > best) begin
        best = v[i];
        bi = i;
      end
    return SEG_TAB[bi];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    bit         prev_rst = 1'b0;
    bit         prev_busy = 1'b0;
    int         idx = 0;
    logic [7:0] mseg = '0;
    forever begin
      @(negedge clk);
      if (prev_rst) begin
        chk("mon_reset_outputs",
            {request_coef, coef_select, node_idx, mac_start, busy, done_processing, aborted, seven_seg}, '0);
        mseg = '0;
      end else begin
        if (busy && !prev_busy) idx = 0;
        if (done_processing) begin
          mseg = m_pending_seg;
          tot_done++;
        end
        chk("mon_seven_seg", seven_seg, mseg);
        if (mac_start) begin
          chk("mon_node_seq", {coef_select, node_idx},
              (idx < NH) ? {1'b0, 4'(idx)} : {1'b1, 4'(idx - NH)});
          idx++;
          tot_ms++;
        end
        chk("mon_done_vs_abort", done_processing & aborted, 0);
        chk("mon_req_without_busy", request_coef & ~busy, 0);
      end
      prev_rst  = rst;
      prev_busy = busy;
    end
  endtask

  task automatic start_run();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_req", request_coef, 1);
    chk("start_busy", busy, 1);
    chk("start_node", {coef_select, node_idx}, 0);
  endtask

  // brk_kind: 0 none, 1 drop load in WAIT_MAC of node brk_at, 2 reset there.
  task automatic do_nodes(input int r0, input int r1, input int r2, input int ack_dly,
                          input bit spur, input int brk_at, input int brk_kind,
                          input logic [7:0] exp_seg);
    int base_ms;
    int base_done;
    int rv[3];
    base_ms   = tot_ms;
    base_done = tot_done;
    rv[0] = r0; rv[1] = r1; rv[2] = r2;
    m_pending_seg = model_seg(r0, r1, r2);
    for (int k = 0; k < NH + NO; k++) begin
      for (int d = 0; d < ack_dly; d++) begin
        chk("req_held", request_coef, 1);
        if (spur) begin
          mac_done = 1'b1;
          start = 1'b1;
        end
        cyc();
        mac_done = 1'b0;
        start = 1'b0;
      end
      chk("req_before_ack", request_coef, 1);
      coef_ack = 1'b1;
      cyc();
      coef_ack = 1'b0;
      chk("mac_start_after_ack", mac_start, 1);
      chk("req_dropped", request_coef, 0);
      cyc();
      chk("mac_start_single", mac_start, 0);
      chk("busy_wait_mac", busy, 1);
      if (k == brk_at && brk_kind == 1) begin
        image_weights_loaded = 1'b0;
        cyc();
        image_weights_loaded = 1'b1;
        chk("abort_pulse", aborted, 1);
        chk("abort_idle", busy, 0);
        chk("abort_req", request_coef, 0);
        chk("abort_seg_kept", seven_seg, exp_seg);
        cyc();
        chk("abort_single", aborted, 0);
        chk("abort_no_done", tot_done - base_done, 0);
        return;
      end
      if (k == brk_at && brk_kind == 2) begin
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_outputs",
            {request_coef, coef_select, node_idx, mac_start, busy, done_processing, aborted, seven_seg}, '0);
        return;
      end
      if (spur) begin
        coef_ack = 1'b1;
        start = 1'b1;
      end
      cyc();
      coef_ack = 1'b0;
      start = 1'b0;
      cyc();
      mac_done = 1'b1;
      mac_result = (k < NH) ? 16'(30000 - k) : 16'(rv[k - NH]);
      cyc();
      mac_done = 1'b0;
      if (k < NH + NO - 1) begin
        chk("next_req", request_coef, 1);
        chk("next_node", {coef_select, node_idx},
            (k + 1 < NH) ? {1'b0, 4'(k + 1)} : {1'b1, 4'(k + 1 - NH)});
      end else begin
        chk("done_pulse", done_processing, 1);
        chk("done_seg", seven_seg, exp_seg);
        cyc();
        chk("done_single", done_processing, 0);
        chk("idle_after_done", busy, 0);
        chk("seg_hold", seven_seg, exp_seg);
      end
    end
    chk("mac_start_count", tot_ms - base_ms, NH + NO);
    chk("done_count", tot_done - base_done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor();
    join_none
    cyc();
    cyc();
    chk("reset_outputs",
        {request_coef, coef_select, node_idx, mac_start, busy, done_processing, aborted, seven_seg}, '0);
    rst = 1'b0;
    image_weights_loaded = 1'b1;
    cyc();
    chk("post_reset_idle", {busy, seven_seg}, '0);

    start_run();
    do_nodes(5, -2, 9, 0, 1'b0, -1, 0, 8'h5B);
    start_run();
    do_nodes(7, 7, -1, 0, 1'b0, -1, 0, 8'h3F);
    start_run();
    do_nodes(-100, -5, -30, 0, 1'b0, -1, 0, 8'h06);
    start_run();
    do_nodes(-32768, -32768, -32768, 0, 1'b0, -1, 0, 8'h3F);

    image_weights_loaded = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("wait_load_busy", busy, 1);
    chk("wait_load_noreq", request_coef, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("wait_load_hold", request_coef, 0);
    end
    image_weights_loaded = 1'b1;
    cyc();
    chk("load_then_req", request_coef, 1);
    do_nodes(1, 2, 3, 4, 1'b1, -1, 0, 8'h5B);

    mac_done = 1'b1;
    coef_ack = 1'b1;
    mac_result = 16'h7FFF;
    cyc();
    mac_done = 1'b0;
    coef_ack = 1'b0;
    chk("idle_spurious", {busy, request_coef, mac_start, done_processing}, 0);
    cyc();
    chk("idle_spurious_hold", {busy, request_coef, mac_start, done_processing}, 0);

    start_run();
    do_nodes(1, 0, 0, 0, 1'b0, 5, 1, 8'h5B);

    start_run();
    do_nodes(5, -2, 9, 0, 1'b0, 2, 2, 8'h00);
    cyc();
    start_run();
    do_nodes(5, -2, 9, 0, 1'b0, -1, 0, 8'h5B);

    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ann_sequencer.md
# ann_sequencer

Top-level sequencing controller for the ANN classifier. Once image and weights are loaded and a start is issued, it walks the hidden layer and then the output layer one neuron at a time, fetching coefficients and triggering the shared MAC neuron datapath for each. It tracks the argmax of the output-layer results and drives the classified digit onto the seven-segment display, signalling `done_processing` when the result is valid.

## Interface
- `N_HIDDEN`, default 16: hidden-layer neuron count, range 1..16.
- `N_OUT`, default 10: output-layer neuron count, range 1..10.
- `ACC_W`, default 16: width of the signed MAC result.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `image_weights_loaded` in 1: level signal; high while image and weight memories hold valid data.
- `start` in 1: single-cycle start request.
- `coef_ack` in 1: coefficient loader has delivered the coefficients for the requested node.
- `mac_done` in 1: single-cycle pulse; `mac_result` is valid in the same cycle.
- `mac_result` in ACC_W: signed two's-complement neuron output.
- `request_coef` out 1: coefficient request, held high until `coef_ack`.
- `coef_select` out 1: layer being processed; 0 = hidden, 1 = output.
- `node_idx` out 4: index of the current neuron within its layer.
- `mac_start` out 1: single-cycle trigger to the neuron datapath.
- `busy` out 1: high in every state except IDLE.
- `done_processing` out 1: single-cycle pulse when the result is valid.
- `aborted` out 1: single-cycle pulse when a run is aborted.
- `seven_seg` out 8: segment pattern of the classified digit, bit order {dp,g,f,e,d,c,b,a}, active-high.

## Operation
- States: IDLE, WAIT_LOAD, REQ, FIRE, WAIT_MAC, DONE.
- IDLE → REQ on `start` while `image_weights_loaded`=1.
- IDLE → WAIT_LOAD on `start` while `image_weights_loaded`=0.
- Entry to REQ from IDLE clears `node_idx`, `coef_select`, `best_val` and `best_idx`.
- WAIT_LOAD → REQ when `image_weights_loaded`=1.
- REQ: `request_coef`=1. Go to FIRE on the cycle `coef_ack`=1.
- FIRE: `mac_start`=1 for exactly one cycle, then go to WAIT_MAC.
- WAIT_MAC, on `mac_done`:
  - When `coef_select`=1, compare `mac_result` against `best_val` as signed values. Update only on strictly greater, so ties keep the lowest index.
  - `best_val` starts at the most-negative ACC_W value.
  - If `node_idx` is not the last index of the layer: increment `node_idx` and go to REQ.
  - Last hidden node (`node_idx`=N_HIDDEN-1): set `coef_select`=1, `node_idx`=0, go to REQ.
  - Last output node (`node_idx`=N_OUT-1): go to DONE.
- DONE: `done_processing`=1 for one cycle, then go to IDLE.
- `seven_seg` loads on the edge entering DONE and reflects all N_OUT results, including the final one.
- Digit encodings: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. `dp` is always 0.
- `seven_seg` holds its value until the next successful DONE.
- Abort: if `image_weights_loaded`=0 in REQ, FIRE or WAIT_MAC, go to IDLE and pulse `aborted` for one cycle. `seven_seg` is unchanged and `done_processing` is not pulsed.
- Ignored inputs:
  - `start` outside IDLE.
  - `mac_done` outside WAIT_MAC.
  - `coef_ack` outside REQ.
- Reset values:
  - State IDLE.
  - All outputs 0, including `seven_seg`=8'h00 (blank).
  - `best_val` and `best_idx` cleared.

## Timing
- Start cycle c with data loaded: REQ and `request_coef` are visible in cycle c+1.
- `coef_ack` in cycle k: `mac_start`=1 in cycle k+1, WAIT_MAC from k+2.
- `mac_done` in cycle m for a non-final node: REQ with the new `node_idx`/`coef_select` in cycle m+1.
- Final `mac_done` in cycle m: `done_processing`=1 and the new `seven_seg` in cycle m+1; IDLE and `busy`=0 in cycle m+2.
- Minimum per-node cost is 3 cycles plus datapath latency (REQ with immediate ack, FIRE, WAIT_MAC with immediate done).
- `rst` mid-run: IDLE on the next edge, no pulses, `seven_seg` cleared.
- `mac_done` and an abort condition in the same WAIT_MAC cycle: abort wins and the result is discarded.

## Test plan
- Reset: assert `rst` 2 cycles → every output 0, `busy`=0, `seven_seg`=00.
- Nominal run (N_HIDDEN=4, N_OUT=3): immediate `coef_ack`, `mac_done` 3 cycles after each `mac_start`, output results 5, -2, 9.
  - Exactly 7 `mac_start` pulses.
  - `coef_select`=0 for the first 4 requests and 1 for the last 3; `node_idx` sequence 0,1,2,3,0,1,2.
  - `seven_seg`=5B and a one-cycle `done_processing` pulse.
- Argmax edge cases:
  - Results 7, 7, -1 → `seven_seg`=3F (tie keeps the lowest index).
  - Results -100, -5, -30 → 06.
  - Results 0x8000, 0x8000, 0x8000 → 3F.
- Start before load: `start` with `image_weights_loaded`=0, then load asserts 5 cycles later → `request_coef` rises on the next cycle. `coef_ack` delayed 4 cycles → `request_coef` stays high throughout and `mac_start` follows the ack by one cycle.
- Abort: after a run showing 5B, drop `image_weights_loaded` while waiting on output node 1 → `aborted` pulse, IDLE next cycle, `seven_seg` stays 5B, no `done_processing`.
- Robustness:
  - Spurious `start`, `mac_done` and `coef_ack` while busy or idle → no state effect.
  - `rst` asserted during WAIT_MAC → IDLE and all outputs 0 next cycle; a following clean run completes normally.
